// File: rtl/demux_gate_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// demux_gate_scheduler_pkg
//   Shared constants for the demux gate scheduler.
//   - Scheduler state encoding. Kept as plain 2-bit constants so existing
//     state decode logic still works.
//   - Requester ID constants.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package demux_gate_scheduler_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/demux_gate_scheduler_if.sv
// -----------------------------------------------------------------------------
// demux_gate_scheduler_if
//   Request and response bundle for the two-requester scheduler.
//   master : the requester/consumer side. It drives the req*_valid/a/b
//            signals and rsp_ready.
//   slave  : the scheduler side. It drives req*_ready, busy and the rsp_*
//            signals.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface demux_gate_scheduler_if #(
   parameter int WIDTH = 8
);
   logic             req0_valid;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req0_ready;
   logic             req1_valid;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             req1_ready;
   logic             busy;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_xor;
   logic [WIDTH-1:0] rsp_xnor;
   logic             rsp_parity;

   modport master (
      output req0_valid, req0_a, req0_b,
      output req1_valid, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready, busy,
      input  rsp_valid, rsp_id, rsp_xor, rsp_xnor, rsp_parity
   );

   modport slave (
      input  req0_valid, req0_a, req0_b,
      input  req1_valid, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready, busy,
      output rsp_valid, rsp_id, rsp_xor, rsp_xnor, rsp_parity
   );
endinterface

// File: rtl/demux_1to2.sv
// -----------------------------------------------------------------------------
// demux_1to2
//   1:2 demultiplexer primitive. It routes din to y0 when sel is 0 and to
//   y1 when sel is 1. The output that is not selected is 0.
//   Ports: din, sel (in); y0, y1 (out).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module demux_1to2 (
   input  logic din,
   input  logic sel,
   output logic y0,
   output logic y1
);
   assign y0 = din & ~sel;
   assign y1 = din &  sel;
endmodule

// File: rtl/demux_xor_xnor_cell.sv
// -----------------------------------------------------------------------------
// demux_xor_xnor_cell
//   Combinational 1-bit XOR/XNOR cell built from 1:2 demux instances.
//   Ports: a, b (in operand bits); bit_xor, bit_xnor (out).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module demux_xor_xnor_cell (
   input  logic a,
   input  logic b,
   output logic bit_xor,
   output logic bit_xnor
);
   logic a_n, a_p;
   logic a_nb, a_b, an_nb, an_b;

   // With din tied to 1, this stage acts as an inverter. It produces ~a and a.
   demux_1to2 u_split_a (.din(1'b1), .sel(a), .y0(a_n), .y1(a_p));

   // These two stages split on b. Together they decode all four minterms of
   // (a, b), and each minterm is one-hot.
   demux_1to2 u_dec_hi  (.din(a_p),  .sel(b), .y0(a_nb),  .y1(a_b));
   demux_1to2 u_dec_lo  (.din(a_n),  .sel(b), .y0(an_nb), .y1(an_b));

   // The minterms are mutually exclusive, so OR-ing them only merges
   // decoder lines.
   assign bit_xor  = a_nb | an_b;
   assign bit_xnor = a_b  | an_nb;
endmodule

// File: rtl/demux_gate_scheduler.sv
// -----------------------------------------------------------------------------
// demux_gate_scheduler
//   Round-robin scheduler for two requesters that share one demux-built
//   XOR/XNOR bit cell. An accepted operand pair is processed one bit per
//   clock, LSB first. The result is returned as XOR word, XNOR word and XOR
//   parity, tagged with the requester ID.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  slave side of demux_gate_scheduler_if (request handshakes, busy,
//          and the response handshake/payload)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module demux_gate_scheduler #(
   parameter int WIDTH = 8
) (
   input logic                  clk,
   input logic                  rst,
   demux_gate_scheduler_if.slave bus
);
   import demux_gate_scheduler_pkg::*;

   localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_q, b_q;
   logic             id_q;
   logic [WIDTH-1:0] xor_sr, xnor_sr;
   logic [WIDTH-1:0] xor_nx, xnor_nx;
   logic             par_q, par_nx;
   logic [CW-1:0]    cnt;
   logic             last_served;

   logic             rsp_valid_q, rsp_id_q, rsp_par_q;
   logic [WIDTH-1:0] rsp_xor_q, rsp_xnor_q;

   logic             grant, ready0, ready1, accept;
   logic             cell_xor, cell_xnor;

   // A tie goes to the requester that was not served last.
   always_comb begin
      grant = REQ0;
      if (bus.req0_valid && bus.req1_valid)
         grant = ~last_served;
      else if (bus.req1_valid)
         grant = REQ1;
   end

   assign ready0 = (state == ST_IDLE) && (grant == REQ0) && !rst;
   assign ready1 = (state == ST_IDLE) && (grant == REQ1) && !rst;
   assign accept = (ready0 && bus.req0_valid) || (ready1 && bus.req1_valid);

   demux_xor_xnor_cell u_cell (
      .a        (a_q[cnt]),
      .b        (b_q[cnt]),
      .bit_xor  (cell_xor),
      .bit_xnor (cell_xnor)
   );

   // Shift-register images that include the bit being processed this cycle.
   // The last SHIFT edge loads these into the response registers.
   always_comb begin
      xor_nx       = xor_sr;
      xnor_nx      = xnor_sr;
      xor_nx[cnt]  = cell_xor;
      xnor_nx[cnt] = cell_xnor;
      par_nx       = par_q ^ cell_xor;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= REQ0;
         xor_sr      <= '0;
         xnor_sr     <= '0;
         par_q       <= 1'b0;
         cnt         <= '0;
         last_served <= REQ1;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= REQ0;
         rsp_xor_q   <= '0;
         rsp_xnor_q  <= '0;
         rsp_par_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_q     <= (grant == REQ1) ? bus.req1_a : bus.req0_a;
                  b_q     <= (grant == REQ1) ? bus.req1_b : bus.req0_b;
                  id_q    <= grant;
                  xor_sr  <= '0;
                  xnor_sr <= '0;
                  par_q   <= 1'b0;
                  cnt     <= '0;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               xor_sr  <= xor_nx;
               xnor_sr <= xnor_nx;
               par_q   <= par_nx;
               if (cnt == LAST) begin
                  rsp_xor_q   <= xor_nx;
                  rsp_xnor_q  <= xnor_nx;
                  rsp_par_q   <= par_nx;
                  rsp_id_q    <= id_q;
                  rsp_valid_q <= 1'b1;
                  state       <= ST_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_valid_q && bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  last_served <= rsp_id_q;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.busy       = (state == ST_SHIFT) || (state == ST_RESP);
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_xor    = rsp_xor_q;
   assign bus.rsp_xnor   = rsp_xnor_q;
   assign bus.rsp_parity = rsp_par_q;
endmodule

// File: tb/tb_demux_gate_scheduler.sv
// -----------------------------------------------------------------------------
// tb_demux_gate_scheduler
//   Directed self-checking bench for demux_gate_scheduler with WIDTH = 8.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demux_gate_scheduler;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   demux_gate_scheduler_if #(.WIDTH(WIDTH)) bus ();

   demux_gate_scheduler #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns the number of edges until rsp_valid rises. The count saturates
   // at 40 if rsp_valid never rises.
   task automatic wait_rsp(output int n);
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic consume();
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_a = 8'h11; bus.req0_b = 8'h22;
      bus.req1_valid = 1'b1; bus.req1_a = 8'h33; bus.req1_b = 8'h44;
      tick(); tick();
      checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b expected 0", bus.req0_ready); end
      checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b expected 0", bus.req1_ready); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
      checks++; if (bus.rsp_xor !== 8'h00 || bus.rsp_xnor !== 8'h00 || bus.rsp_parity !== 1'b0 || bus.rsp_id !== 1'b0)
         begin errors++; $display("FAIL reset_rsp_regs: got xor=%h xnor=%h par=%b id=%b expected all 0", bus.rsp_xor, bus.rsp_xnor, bus.rsp_parity, bus.rsp_id); end
      rst = 1'b0;
      #1;
      checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL release_ready0: got %b expected 1", bus.req0_ready); end
      checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL release_ready1: got %b expected 0", bus.req1_ready); end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      n = 0;
   endtask

   task automatic test_single();
      int n;
      bus.req0_valid = 1'b1; bus.req0_a = 8'hA5; bus.req0_b = 8'h3C;
      #1;
      checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0: got %b expected 1", bus.req0_ready); end
      tick();
      // The requester moves on. Operands changed after acceptance must be ignored.
      bus.req0_valid = 1'b0; bus.req0_a = 8'h00; bus.req0_b = 8'hFF;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
      wait_rsp(n);
      checks++; if (n != 8) begin errors++; $display("FAIL single_latency: got %0d expected 8", n); end
      checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL single_id: got %b expected 0", bus.rsp_id); end
      checks++; if (bus.rsp_xor !== 8'h99) begin errors++; $display("FAIL single_xor: got %h expected 99", bus.rsp_xor); end
      checks++; if (bus.rsp_xnor !== 8'h66) begin errors++; $display("FAIL single_xnor: got %h expected 66", bus.rsp_xnor); end
      checks++; if (bus.rsp_parity !== 1'b0) begin errors++; $display("FAIL single_parity: got %b expected 0", bus.rsp_parity); end
      consume();
      checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
         begin errors++; $display("FAIL single_release: got valid=%b busy=%b expected 0/0", bus.rsp_valid, bus.busy); end
   endtask

   task automatic test_equal();
      int n;
      bus.req1_valid = 1'b1; bus.req1_a = 8'hFF; bus.req1_b = 8'hFF;
      #1;
      checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL equal_ready1: got %b expected 1", bus.req1_ready); end
      tick();
      bus.req1_valid = 1'b0;
      wait_rsp(n);
      checks++; if (n != 8) begin errors++; $display("FAIL equal_latency: got %0d expected 8", n); end
      checks++; if (bus.rsp_id !== 1'b1) begin errors++; $display("FAIL equal_id: got %b expected 1", bus.rsp_id); end
      checks++; if (bus.rsp_xor !== 8'h00) begin errors++; $display("FAIL equal_xor: got %h expected 00", bus.rsp_xor); end
      checks++; if (bus.rsp_xnor !== 8'hFF) begin errors++; $display("FAIL equal_xnor: got %h expected ff", bus.rsp_xnor); end
      checks++; if (bus.rsp_parity !== 1'b0) begin errors++; $display("FAIL equal_parity: got %b expected 0", bus.rsp_parity); end
      consume();
   endtask

   task automatic test_round_robin();
      int n;
      bus.req0_valid = 1'b1; bus.req0_a = 8'hFF; bus.req0_b = 8'h00;
      bus.req1_valid = 1'b1; bus.req1_a = 8'h0F; bus.req1_b = 8'h01;
      #1;
      checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
         begin errors++; $display("FAIL rr_grant1: got r0=%b r1=%b expected 1/0", bus.req0_ready, bus.req1_ready); end
      tick();
      bus.req0_a = 8'h80; bus.req0_b = 8'h00;
      wait_rsp(n);
      checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_xor !== 8'hFF || bus.rsp_xnor !== 8'h00 || bus.rsp_parity !== 1'b0)
         begin errors++; $display("FAIL rr_rsp_req0: got id=%b xor=%h xnor=%h par=%b expected 0/ff/00/0", bus.rsp_id, bus.rsp_xor, bus.rsp_xnor, bus.rsp_parity); end
      consume();
      checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1)
         begin errors++; $display("FAIL rr_grant2: got r0=%b r1=%b expected 0/1", bus.req0_ready, bus.req1_ready); end
      tick();
      wait_rsp(n);
      checks++; if (bus.rsp_id !== 1'b1 || bus.rsp_xor !== 8'h0E || bus.rsp_xnor !== 8'hF1 || bus.rsp_parity !== 1'b1)
         begin errors++; $display("FAIL rr_rsp_req1: got id=%b xor=%h xnor=%h par=%b expected 1/0e/f1/1", bus.rsp_id, bus.rsp_xor, bus.rsp_xnor, bus.rsp_parity); end
      consume();
      checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
         begin errors++; $display("FAIL rr_grant3: got r0=%b r1=%b expected 1/0", bus.req0_ready, bus.req1_ready); end
      tick();
      wait_rsp(n);
      checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_xor !== 8'h80 || bus.rsp_xnor !== 8'h7F || bus.rsp_parity !== 1'b1)
         begin errors++; $display("FAIL rr_bit_order: got id=%b xor=%h xnor=%h par=%b expected 0/80/7f/1", bus.rsp_id, bus.rsp_xor, bus.rsp_xnor, bus.rsp_parity); end
      consume();
      checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1)
         begin errors++; $display("FAIL rr_grant4: got r0=%b r1=%b expected 0/1", bus.req0_ready, bus.req1_ready); end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      #1;
   endtask

   task automatic test_backpressure();
      int n;
      bus.req0_valid = 1'b1; bus.req0_a = 8'hAA; bus.req0_b = 8'hAA;
      bus.req1_valid = 1'b1; bus.req1_a = 8'h12; bus.req1_b = 8'h34;
      #1;
      checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b expected 1", bus.req1_ready); end
      tick();
      bus.req1_valid = 1'b0;
      wait_rsp(n);
      checks++; if (n != 8) begin errors++; $display("FAIL bp_latency: got %0d expected 8", n); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_xor !== 8'h26 || bus.rsp_xnor !== 8'hD9 || bus.rsp_parity !== 1'b1)
            begin errors++; $display("FAIL bp_hold_%0d: got v=%b id=%b xor=%h xnor=%h par=%b expected 1/1/26/d9/1", i, bus.rsp_valid, bus.rsp_id, bus.rsp_xor, bus.rsp_xnor, bus.rsp_parity); end
         checks++; if (bus.busy !== 1'b1 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
            begin errors++; $display("FAIL bp_stall_%0d: got busy=%b r0=%b r1=%b expected 1/0/0", i, bus.busy, bus.req0_ready, bus.req1_ready); end
         tick();
      end
      consume();
      checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
         begin errors++; $display("FAIL bp_release: got valid=%b busy=%b expected 0/0", bus.rsp_valid, bus.busy); end
      checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
         begin errors++; $display("FAIL bp_next_grant: got r0=%b r1=%b expected 1/0", bus.req0_ready, bus.req1_ready); end
      checks++; if (bus.rsp_xor !== 8'h26) begin errors++; $display("FAIL bp_xor_kept: got %h expected 26", bus.rsp_xor); end
      bus.req0_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset_mid();
      int n;
      bus.req1_valid = 1'b1; bus.req1_a = 8'h5A; bus.req1_b = 8'h0F;
      #1;
      checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL mid_ready1: got %b expected 1", bus.req1_ready); end
      tick();
      repeat (4) tick();
      checks++; if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0)
         begin errors++; $display("FAIL mid_shifting: got busy=%b valid=%b expected 1/0", bus.busy, bus.rsp_valid); end
      bus.req0_valid = 1'b1; bus.req0_a = 8'h01; bus.req0_b = 8'h02;
      rst = 1'b1;
      tick(); tick();
      checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
         begin errors++; $display("FAIL mid_in_reset: got v=%b busy=%b r0=%b r1=%b expected all 0", bus.rsp_valid, bus.busy, bus.req0_ready, bus.req1_ready); end
      rst = 1'b0;
      #1;
      checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
         begin errors++; $display("FAIL mid_after_grant: got r0=%b r1=%b expected 1/0", bus.req0_ready, bus.req1_ready); end
      tick();
      bus.req0_valid = 1'b0;
      wait_rsp(n);
      checks++; if (n != 8) begin errors++; $display("FAIL mid_req0_latency: got %0d expected 8", n); end
      checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_xor !== 8'h03 || bus.rsp_xnor !== 8'hFC || bus.rsp_parity !== 1'b0)
         begin errors++; $display("FAIL mid_req0_rsp: got id=%b xor=%h xnor=%h par=%b expected 0/03/fc/0", bus.rsp_id, bus.rsp_xor, bus.rsp_xnor, bus.rsp_parity); end
      consume();
      checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL mid_reaccept: got %b expected 1", bus.req1_ready); end
      tick();
      bus.req1_valid = 1'b0;
      wait_rsp(n);
      checks++; if (bus.rsp_id !== 1'b1 || bus.rsp_xor !== 8'h55 || bus.rsp_xnor !== 8'hAA || bus.rsp_parity !== 1'b0)
         begin errors++; $display("FAIL mid_req1_rsp: got id=%b xor=%h xnor=%h par=%b expected 1/55/aa/0", bus.rsp_id, bus.rsp_xor, bus.rsp_xnor, bus.rsp_parity); end
      consume();
   endtask

   initial begin
      rst = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
      bus.rsp_ready  = 1'b0;
      test_reset();
      test_single();
      test_equal();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
